// File: rtl/jt49_eg_mc_pkg.sv
// Shared definitions for the multi-channel AY-3-8910 style envelope generator:
// shape-control bit positions and the end-of-ramp decision terms.
package jt49_eg_mc_pkg;

    localparam int EG_CONT = 3;
    localparam int EG_ATT  = 2;
    localparam int EG_ALT  = 1;
    localparam int EG_HOLD = 0;

    typedef logic [3:0] eg_ctrl_t;

    // At the bottom of a ramp: freeze the channel instead of wrapping?
    function automatic logic eg_will_hold(input eg_ctrl_t ctrl);
        return !ctrl[EG_CONT] || ctrl[EG_HOLD];
    endfunction

    // At the bottom of a ramp: flip the output polarity?
    function automatic logic eg_toggle(input eg_ctrl_t ctrl);
        return (!ctrl[EG_CONT] && ctrl[EG_ATT]) || (ctrl[EG_CONT] && ctrl[EG_ALT]);
    endfunction

endpackage

// File: rtl/jt49_eg_ch.sv
// One envelope channel: step-period counter plus gain/invert/stop state.
// Outputs show the state as it was before the current cen update.
module jt49_eg_ch
    import jt49_eg_mc_pkg::*;
#(
    parameter int GW = 5,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          restart,
    input  logic [3:0]    ctrl,
    input  logic [PW-1:0] period,
    output logic [GW-1:0] env,
    output logic          active
);

    localparam logic [GW-1:0] GAIN_MAX = '1;

    logic [PW-1:0] cnt;
    logic [GW-1:0] gain;
    logic          inv;
    logic          stop;

    logic [PW-1:0] per_eff;
    logic [PW:0]   cnt_inc;
    logic          step;

    // A period of 0 behaves like 1; >= lets a shrunk period fire immediately.
    assign per_eff = (period == '0) ? PW'(1) : period;
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign step    = cnt_inc >= {1'b0, per_eff};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            gain   <= GAIN_MAX;
            inv    <= 1'b0;
            stop   <= 1'b0;
            env    <= '0;
            active <= 1'b0;
        end else if (cen) begin
            env    <= inv ? ~gain : gain;
            active <= !stop;
            if (restart) begin
                cnt  <= '0;
                gain <= GAIN_MAX;
                inv  <= ctrl[EG_ATT];
                stop <= 1'b0;
            end else begin
                cnt <= step ? '0 : cnt + 1'b1;
                if (step && !stop) begin
                    if (gain != '0) begin
                        gain <= gain - 1'b1;
                    end else begin
                        // Bottom of the ramp: shape bits are read only here.
                        if (eg_will_hold(ctrl)) stop <= 1'b1;
                        else                    gain <= GAIN_MAX;
                        if (eg_toggle(ctrl)) inv <= ~inv;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/jt49_eg_mc.sv
// Multi-channel envelope generator: CH independent channels sliced out of
// packed per-channel buses; no logic is shared between channels.
module jt49_eg_mc #(
    parameter int CH = 3,
    parameter int GW = 5,
    parameter int PW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic [CH-1:0]    restart,
    input  logic [4*CH-1:0]  ctrl,
    input  logic [PW*CH-1:0] period,
    output logic [GW*CH-1:0] env,
    output logic [CH-1:0]    active
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        jt49_eg_ch #(
            .GW(GW),
            .PW(PW)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .cen    (cen),
            .restart(restart[i]),
            .ctrl   (ctrl[4*i +: 4]),
            .period (period[PW*i +: PW]),
            .env    (env[GW*i +: GW]),
            .active (active[i])
        );
    end

endmodule

// File: tb/tb_jt49_eg_mc.sv
// Scoreboard bench for jt49_eg_mc: stimulus queues expected per-channel outputs
// tagged with the cen edge they belong to; a monitor pops and compares them.
module tb_jt49_eg_mc;

    localparam int CH   = 3;
    localparam int GW   = 5;
    localparam int PW   = 16;
    localparam int GMAX = 31;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cen;
    logic [CH-1:0]    restart;
    logic [4*CH-1:0]  ctrl;
    logic [PW*CH-1:0] period;
    logic [GW*CH-1:0] env;
    logic [CH-1:0]    active;

    jt49_eg_mc #(.CH(CH), .GW(GW), .PW(PW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen),
        .restart(restart),
        .ctrl   (ctrl),
        .period (period),
        .env    (env),
        .active (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    idx;
        int    ch;
        int    env;
        bit    act;
        string tag;
    } exp_t;

    exp_t q[$];
    int   ecnt = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   done = 0;
    bit   use_model = 0;
    bit   freeze_chk = 0;
    logic [GW*CH-1:0] snap_env;
    logic [CH-1:0]    snap_act;

    // Count of clock edges on which the outputs are allowed to change.
    always @(posedge clk) if (cen || !rst_n) ecnt <= ecnt + 1;

    task automatic push_exp(input int ch, input int e, input bit a, input string tag);
        exp_t x;
        x.idx = ecnt + 1;
        x.ch  = ch;
        x.env = e;
        x.act = a;
        x.tag = tag;
        q.push_back(x);
    endtask

    int m_gain[CH];
    int m_cnt[CH];
    bit m_inv[CH];
    bit m_stop[CH];
    bit m_ok[CH];

    task automatic model_tick();
        for (int i = 0; i < CH; i++) begin
            logic [3:0] c;
            int per;
            bit st;
            c   = ctrl[4*i +: 4];
            per = int'(period[PW*i +: PW]);
            if (per == 0) per = 1;
            if (m_ok[i]) push_exp(i, m_inv[i] ? GMAX - m_gain[i] : m_gain[i], !m_stop[i], "model");
            if (restart[i]) begin
                m_cnt[i]  = 0;
                m_gain[i] = GMAX;
                m_inv[i]  = c[2];
                m_stop[i] = 0;
                m_ok[i]   = 1;
            end else begin
                st = (m_cnt[i] + 1 >= per);
                m_cnt[i] = st ? 0 : m_cnt[i] + 1;
                if (st && !m_stop[i]) begin
                    if (m_gain[i] > 0) m_gain[i] = m_gain[i] - 1;
                    else begin
                        if (!c[3] || c[0]) m_stop[i] = 1;
                        else               m_gain[i] = GMAX;
                        if (c[3] ? c[1] : c[2]) m_inv[i] = !m_inv[i];
                    end
                end
            end
        end
    endtask

    task automatic tick();
        if (use_model && cen && rst_n) model_tick();
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, got no finish, want finish");
        $fatal(1);
    end

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (freeze_chk) begin
                n_chk++;
                if (env !== snap_env || active !== snap_act)
                    $display("FAIL freeze: got env=%h active=%b, want env=%h active=%b",
                             env, active, snap_env, snap_act);
                else n_pass++;
            end
            while (q.size() > 0 && q[0].idx <= ecnt) begin
                e = q.pop_front();
                n_chk++;
                if (e.idx != ecnt)
                    $display("FAIL %s ch%0d: edge %0d not checked in time, got edge %0d",
                             e.tag, e.ch, e.idx, ecnt);
                else if (env[e.ch*GW +: GW] !== GW'(e.env) || active[e.ch] !== e.act)
                    $display("FAIL %s ch%0d edge %0d: got env=%0d active=%b, want env=%0d active=%b",
                             e.tag, e.ch, e.idx, env[e.ch*GW +: GW], active[e.ch], e.env, e.act);
                else n_pass++;
            end
        end
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : stimulus
        rst_n   = 1'b0;
        cen     = 1'b1;
        restart = '0;
        ctrl    = '0;
        period  = {CH{16'd1}};

        // Reset with cen high, then first cen after release
        repeat (3) begin
            for (int i = 0; i < CH; i++) push_exp(i, 0, 0, "reset");
            tick();
        end
        rst_n = 1'b1;
        for (int i = 0; i < CH; i++) push_exp(i, GMAX, 1, "reset_rel");
        tick();

        // CH0 single decay, then hold 0
        ctrl[3:0]    = 4'b0000;
        period[15:0] = 16'd1;
        restart      = 3'b001;
        tick();
        restart = '0;
        for (int k = 1; k <= 36; k++) begin
            push_exp(0, (k <= 32) ? 32 - k : 0, k <= 32, "t2_decay");
            tick();
        end

        // CH1 triangle, period 2
        ctrl[7:4]     = 4'b1010;
        period[31:16] = 16'd2;
        restart       = 3'b010;
        tick();
        restart = '0;
        for (int k = 1; k <= 140; k++) begin
            int m;
            m = ((k - 1) / 2) % 64;
            push_exp(1, (m < 32) ? 31 - m : m - 32, 1, "t3_tri");
            tick();
        end

        // CH2 down once then hold high, period 0
        ctrl[11:8]    = 4'b1011;
        period[47:32] = 16'd0;
        restart       = 3'b100;
        tick();
        restart = '0;
        for (int k = 1; k <= 36; k++) begin
            push_exp(2, (k <= 32) ? 32 - k : 31, k <= 32, "t4_hold");
            tick();
        end

        // CH0 restart colliding with a step at gain 10
        period[15:0] = 16'd3;
        restart      = 3'b001;
        tick();
        restart = '0;
        for (int k = 1; k <= 65; k++) begin
            push_exp(0, 31 - (k - 1) / 3, 1, "t5_pre");
            tick();
        end
        restart = 3'b001;
        push_exp(0, 10, 1, "t5_collide");
        tick();
        restart = '0;
        for (int j = 1; j <= 7; j++) begin
            push_exp(0, 31 - (j - 1) / 3, 1, "t5_after");
            tick();
        end

        // All channels together against the model, with a cen freeze
        ctrl          = {4'b0100, 4'b1110, 4'b1000};
        period        = {16'd2, 16'd1, 16'd3};
        restart       = '1;
        use_model     = 1;
        tick();
        restart = '0;
        repeat (40) tick();
        ctrl[3:0]    = 4'b1011;
        period[15:0] = 16'd9;
        repeat (10) tick();
        period[15:0] = 16'd2;
        repeat (20) tick();
        restart = 3'b110;
        tick();
        restart = '0;
        repeat (10) tick();

        snap_env   = env;
        snap_act   = active;
        cen        = 1'b0;
        restart    = '1;
        freeze_chk = 1;
        repeat (50) @(negedge clk);
        freeze_chk = 0;
        cen        = 1'b1;
        restart    = '0;
        repeat (40) tick();

        // Reset mid-envelope with cen low, then release
        use_model = 0;
        rst_n     = 1'b0;
        cen       = 1'b0;
        for (int i = 0; i < CH; i++) push_exp(i, 0, 0, "rst_mid");
        tick();
        rst_n = 1'b1;
        cen   = 1'b1;
        for (int i = 0; i < CH; i++) push_exp(i, GMAX, 1, "rst_mid_rel");
        tick();

        repeat (2) @(negedge clk);
        done = 1;
    end

endmodule
